round_tracker: RTL and testbench

Sequential round controller and scorekeeper for the whack-a-mole game. It sits directly downstream of the combinational hit checker. It gates that checker with `start_checks`, consumes exactly one `give_lose_point` verdict per round, and keeps the score and remaining lives. It also asks the random-number stage for a new target through `new_round`, and raises `game_over` when lives reach zero.

---
 rtl/round_tracker.sv | 152 +++++++++++++++
 tb/tb_round_tracker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/round_tracker.sv
// round_tracker: round sequencer and scorekeeper for the whack-a-mole game.
// Gates the hit checker (start_checks), consumes one verdict per round,
// keeps score and lives, requests new targets (new_round) and flags game_over.
//
// Ports:
//   clk              single clock
//   rst              synchronous, active-low reset
//   start_game       level; honoured only in IDLE and GAME_OVER
//   buttons[3:0]     raw buttons, active-low (4'b1111 = none pressed)
//   give_lose_point  checker verdict: 2'b11 hit, 2'b01 wrong, else no event
//   start_checks     checker enable (registered)
//   new_round        one-cycle pulse asking the random stage for a new target
//   score            hits this game, saturating
//   lives[3:0]       remaining lives
//   game_over        high while in GAME_OVER
module round_tracker #(
  parameter int unsigned START_LIVES     = 3,
  parameter int unsigned SCORE_WIDTH     = 8,
  parameter int unsigned COOLDOWN_CYCLES = 25_000_000,
  parameter int unsigned ROUND_CYCLES    = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_game,
  input  logic [3:0]             buttons,
  input  logic [1:0]             give_lose_point,
  output logic                   start_checks,
  output logic                   new_round,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [3:0]             lives,
  output logic                   game_over
);

  // One timer serves both COOLDOWN and ARMED; it is sized for the longer one.
  localparam int unsigned MAX_CYCLES = (COOLDOWN_CYCLES > ROUND_CYCLES) ?
                                       COOLDOWN_CYCLES : ROUND_CYCLES;
  localparam int unsigned TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int unsigned LW         = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COOLDOWN,
    S_ARMED,
    S_RELEASE,
    S_GAME_OVER
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [TW-1:0]          timer;
  logic [TW-1:0]          timer_nxt;
  logic [SCORE_WIDTH-1:0] score_nxt;
  logic [LW-1:0]          lives_nxt;
  logic                   start_checks_nxt;
  logic                   new_round_nxt;
  logic                   game_over_nxt;

  logic hit;
  logic wrong;
  logic timeout;
  logic cool_done;
  logic all_released;

  assign hit          = (give_lose_point == 2'b11);
  assign wrong        = (give_lose_point == 2'b01);
  assign timeout      = (timer == TW'(ROUND_CYCLES - 1));
  assign cool_done    = (timer == TW'(COOLDOWN_CYCLES - 1));
  assign all_released = (buttons == 4'b1111);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      score        <= '0;
      lives        <= LW'(START_LIVES);
      start_checks <= 1'b0;
      new_round    <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      score        <= score_nxt;
      lives        <= lives_nxt;
      start_checks <= start_checks_nxt;
      new_round    <= new_round_nxt;
      game_over    <= game_over_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_game) state_nxt = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (cool_done) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        // A verdict outranks a coincident timeout; a hit never costs a life.
        if (hit) begin
          state_nxt = S_RELEASE;
        end else if (wrong || timeout) begin
          state_nxt = (lives <= LW'(1)) ? S_GAME_OVER : S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (all_released) state_nxt = S_COOLDOWN;
      end
      S_GAME_OVER: begin
        if (start_game) state_nxt = S_COOLDOWN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs
  always_comb begin
    score_nxt        = score;
    lives_nxt        = lives;
    timer_nxt        = '0;
    start_checks_nxt = (state_nxt == S_ARMED);
    game_over_nxt    = (state_nxt == S_GAME_OVER);
    new_round_nxt    = (state_nxt == S_COOLDOWN) && (state != S_COOLDOWN);

    // Timer restarts from zero on every state change.
    if (((state == S_COOLDOWN) || (state == S_ARMED)) && (state_nxt == state)) begin
      timer_nxt = timer + TW'(1);
    end

    case (state)
      S_IDLE, S_GAME_OVER: begin
        if (start_game) begin
          score_nxt = '0;
          lives_nxt = LW'(START_LIVES);
        end
      end
      S_ARMED: begin
        if (hit) begin
          if (score != '1) score_nxt = score + SCORE_WIDTH'(1);
        end else if ((wrong || timeout) && (lives != '0)) begin
          lives_nxt = lives - LW'(1);
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_round_tracker.sv
// Directed bench for round_tracker with START_LIVES=3, SCORE_WIDTH=4,
// COOLDOWN_CYCLES=4, ROUND_CYCLES=16. Inputs change 1 ns after a rising
// edge; outputs are sampled at that same point.
module tb_round_tracker;

  logic       clk;
  logic       rst;
  logic       start_game;
  logic [3:0] buttons;
  logic [1:0] give_lose_point;
  logic       start_checks;
  logic       new_round;
  logic [3:0] score;
  logic [3:0] lives;
  logic       game_over;

  int checks   = 0;
  int failures = 0;

  round_tracker #(
    .START_LIVES    (3),
    .SCORE_WIDTH    (4),
    .COOLDOWN_CYCLES(4),
    .ROUND_CYCLES   (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_game     (start_game),
    .buttons        (buttons),
    .give_lose_point(give_lose_point),
    .start_checks   (start_checks),
    .new_round      (new_round),
    .score          (score),
    .lives          (lives),
    .game_over      (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edge that enters COOLDOWN, then the four cooldown edges up to ARMED.
  task automatic enter_round(input int exp_score, input int exp_lives);
    step();
    start_game = 1'b0;
    chk("nr_pulse", int'(new_round), 1);
    chk("nr_sc_low", int'(start_checks), 0);
    chk("nr_go_low", int'(game_over), 0);
    chk("nr_score", int'(score), exp_score);
    chk("nr_lives", int'(lives), exp_lives);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("cd_nr_low", int'(new_round), 0);
      chk("cd_sc", int'(start_checks), (i == 4) ? 1 : 0);
      chk("cd_score", int'(score), exp_score);
    end
  endtask

  // Let the round time out; the final edge charges the miss.
  task automatic run_timeout(input int exp_score, input int lives_before);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("to_sc", int'(start_checks), (i < 16) ? 1 : 0);
      chk("to_lives", int'(lives), (i < 16) ? lives_before : lives_before - 1);
      chk("to_score", int'(score), exp_score);
    end
  endtask

  initial begin
    rst             = 1'b0;
    start_game      = 1'b0;
    buttons         = 4'b1111;
    give_lose_point = 2'b00;

    // Reset state
    step();
    step();
    rst = 1'b1;
    chk("rst_sc", int'(start_checks), 0);
    chk("rst_nr", int'(new_round), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_go", int'(game_over), 0);
    step();
    chk("idle_nr", int'(new_round), 0);
    chk("idle_sc", int'(start_checks), 0);

    // Start and first round
    start_game = 1'b1;
    enter_round(0, 3);

    // Hit with button 0 held; verdict stays stuck at 11 through RELEASE and COOLDOWN
    give_lose_point = 2'b11;
    buttons         = 4'b1110;
    step();
    chk("hit_score", int'(score), 1);
    chk("hit_sc", int'(start_checks), 0);
    chk("hit_nr", int'(new_round), 0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("hold_score", int'(score), 1);
      chk("hold_nr", int'(new_round), 0);
      chk("hold_sc", int'(start_checks), 0);
    end
    buttons = 4'b1111;
    enter_round(1, 3);
    give_lose_point = 2'b00;

    // Timeout miss
    run_timeout(1, 3);
    enter_round(1, 2);

    // Wrong button
    give_lose_point = 2'b01;
    step();
    give_lose_point = 2'b00;
    chk("wrong_lives", int'(lives), 1);
    chk("wrong_score", int'(score), 1);
    chk("wrong_sc", int'(start_checks), 0);
    enter_round(1, 1);

    // Third miss ends the game
    run_timeout(1, 1);
    chk("go_flag", int'(game_over), 1);
    chk("go_lives", int'(lives), 0);
    give_lose_point = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("go_hold_score", int'(score), 1);
      chk("go_hold_lives", int'(lives), 0);
      chk("go_hold_flag", int'(game_over), 1);
      chk("go_hold_sc", int'(start_checks), 0);
      chk("go_hold_nr", int'(new_round), 0);
    end
    give_lose_point = 2'b00;

    // Restart from GAME_OVER
    start_game = 1'b1;
    enter_round(0, 3);

    // Hit on the timeout cycle: score increments, no life lost
    for (int i = 0; i < 15; i++) step();
    chk("tie_pre_sc", int'(start_checks), 1);
    give_lose_point = 2'b11;
    step();
    give_lose_point = 2'b00;
    chk("tie_score", int'(score), 1);
    chk("tie_lives", int'(lives), 3);
    chk("tie_sc", int'(start_checks), 0);
    enter_round(1, 3);

    // Saturation: 16 more hits take the score from 1 to the 15 ceiling
    for (int k = 1; k <= 16; k++) begin
      give_lose_point = 2'b11;
      step();
      give_lose_point = 2'b00;
      chk("sat_score", int'(score), (1 + k > 15) ? 15 : 1 + k);
      chk("sat_lives", int'(lives), 3);
      enter_round((1 + k > 15) ? 15 : 1 + k, 3);
    end

    // Reset mid-ARMED
    step();
    chk("pre_rst_sc", int'(start_checks), 1);
    rst = 1'b0;
    step();
    chk("mid_rst_sc", int'(start_checks), 0);
    chk("mid_rst_score", int'(score), 0);
    chk("mid_rst_lives", int'(lives), 3);
    chk("mid_rst_go", int'(game_over), 0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_sc", int'(start_checks), 0);
      chk("post_rst_nr", int'(new_round), 0);
      chk("post_rst_score", int'(score), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
